// File: rtl/vga_frame_reader.sv
`default_nettype none
// ============================================================================
// Module   : vga_frame_reader
// Purpose  : VGA scan-out engine that reads a half-resolution image from the
//            frame buffer SRAM and doubles it in both directions.
// Revision : 1.0
// ============================================================================
module vga_frame_reader #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int SRC_WIDTH  = 320,
  parameter int ADDR_WIDTH = 17,
  parameter int DATA_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  input  logic [DATA_WIDTH-1:0] sram_dout,
  output logic [3:0]            vga_r,
  output logic [3:0]            vga_g,
  output logic [3:0]            vga_b,
  output logic                  vga_hsync,
  output logic                  vga_vsync,
  output logic                  vga_de,
  output logic                  frame_start
);

  localparam int c_h_total = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int c_v_total = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int c_hw      = $clog2(c_h_total);
  localparam int c_vw      = $clog2(c_v_total);

  localparam logic [c_hw-1:0] c_h_last     = c_hw'(c_h_total - 1);
  localparam logic [c_hw-1:0] c_h_act      = c_hw'(H_ACTIVE);
  localparam logic [c_hw-1:0] c_hs_start   = c_hw'(H_ACTIVE + H_FP);
  localparam logic [c_hw-1:0] c_hs_end     = c_hw'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [c_vw-1:0] c_v_last     = c_vw'(c_v_total - 1);
  localparam logic [c_vw-1:0] c_v_act      = c_vw'(V_ACTIVE);
  localparam logic [c_vw-1:0] c_vs_start   = c_vw'(V_ACTIVE + V_FP);
  localparam logic [c_vw-1:0] c_vs_end     = c_vw'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [ADDR_WIDTH-1:0] c_src  = ADDR_WIDTH'(SRC_WIDTH);

  logic [c_hw-1:0]       r_h;
  logic [c_vw-1:0]       r_v;
  logic [ADDR_WIDTH-1:0] r_line_base;

  logic                  w_h_wrap;
  logic                  w_v_wrap;
  logic                  w_active;
  logic                  w_hsync_n;
  logic                  w_vsync_n;
  logic                  w_first;
  logic [ADDR_WIDTH-1:0] w_addr;

  // Stage-1 and stage-2 copies of the timing flags, matching the SRAM latency
  logic r_de1, r_hs1, r_vs1, r_fs1;
  logic r_de2, r_hs2, r_vs2, r_fs2;

  assign w_h_wrap  = (r_h == c_h_last);
  assign w_v_wrap  = w_h_wrap && (r_v == c_v_last);
  assign w_active  = (r_h < c_h_act) && (r_v < c_v_act);
  assign w_hsync_n = !((r_h >= c_hs_start) && (r_h < c_hs_end));
  assign w_vsync_n = !((r_v >= c_vs_start) && (r_v < c_vs_end));
  assign w_first   = (r_h == '0) && (r_v == '0);
  assign w_addr    = w_active ? (r_line_base + ADDR_WIDTH'(r_h[c_hw-1:1]))
                              : '0;

  // line_base steps once per pair of lines, giving vertical doubling
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_h         <= '0;
      r_v         <= '0;
      r_line_base <= '0;
    end else begin
      if (w_h_wrap) begin
        r_h <= '0;
        r_v <= w_v_wrap ? '0 : r_v + 1'b1;
      end else begin
        r_h <= r_h + 1'b1;
      end

      if (w_v_wrap) begin
        r_line_base <= '0;
      end else if (w_h_wrap && r_v[0] && (r_v < c_v_act)) begin
        r_line_base <= r_line_base + c_src;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sram_addr <= '0;
      r_de1     <= 1'b0;
      r_hs1     <= 1'b1;
      r_vs1     <= 1'b1;
      r_fs1     <= 1'b0;
      r_de2     <= 1'b0;
      r_hs2     <= 1'b1;
      r_vs2     <= 1'b1;
      r_fs2     <= 1'b0;
    end else begin
      sram_addr <= w_addr;
      r_de1     <= w_active;
      r_hs1     <= w_hsync_n;
      r_vs1     <= w_vsync_n;
      r_fs1     <= w_first;
      r_de2     <= r_de1;
      r_hs2     <= r_hs1;
      r_vs2     <= r_vs1;
      r_fs2     <= r_fs1;
    end
  end

  // Output stage: sram_dout now belongs to the pixel flagged by the stage-2 copies
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vga_r       <= 4'd0;
      vga_g       <= 4'd0;
      vga_b       <= 4'd0;
      vga_de      <= 1'b0;
      vga_hsync   <= 1'b1;
      vga_vsync   <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      vga_r       <= r_de2 ? sram_dout[11:8] : 4'd0;
      vga_g       <= r_de2 ? sram_dout[7:4]  : 4'd0;
      vga_b       <= r_de2 ? sram_dout[3:0]  : 4'd0;
      vga_de      <= r_de2;
      vga_hsync   <= r_hs2;
      vga_vsync   <= r_vs2;
      frame_start <= r_fs2;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_vga_frame_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_frame_reader
// Purpose  : Scoreboard bench for vga_frame_reader: full 640x480 timing plus a
//            reduced geometry instance that completes whole frames quickly.
// Revision : 1.0
// ============================================================================
module tb_vga_frame_reader;

  typedef struct packed {
    logic [9:0]  h;
    logic [9:0]  v;
    logic [16:0] addr;
    logic [11:0] rgb;
    logic        de;
    logic        hs;
    logic        vs;
    logic        fs;
  } exp_t;

  logic            clk;
  logic [1:0]      rst_n;
  logic [11:0]     ov0;
  logic [11:0]     ov1;
  int              checks;
  int              errors;

  logic [1:0][16:0] addr_w;
  logic [1:0][11:0] rgb_w;
  logic [1:0]       de_w;
  logic [1:0]       fs_w;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM contents: two directed words at 0 and 1, a fixed pattern elsewhere
  function automatic logic [11:0] pat(input logic [16:0] a);
    if (a == 17'd0) return ov0;
    if (a == 17'd1) return ov1;
    return 12'(int'(a) * 37 + 5);
  endfunction

  for (genvar G = 0; G < 2; G++) begin : g_dut
    localparam int HA  = (G == 0) ? 640 : 16;
    localparam int HFP = (G == 0) ? 16  : 2;
    localparam int HS  = (G == 0) ? 96  : 3;
    localparam int HBP = (G == 0) ? 48  : 3;
    localparam int VA  = (G == 0) ? 480 : 8;
    localparam int VFP = (G == 0) ? 10  : 2;
    localparam int VS  = 2;
    localparam int VBP = (G == 0) ? 33  : 3;
    localparam int SRC = HA / 2;
    localparam int HT  = HA + HFP + HS + HBP;
    localparam int VT  = VA + VFP + VS + VBP;

    logic [16:0] addr;
    logic [11:0] dout;
    logic [3:0]  cr, cg, cb;
    logic        hs, vs, de, fs;
    exp_t        q[$];
    exp_t        drv_e;
    exp_t        mon_e;
    int          mh, mv;

    vga_frame_reader #(
      .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
      .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
      .SRC_WIDTH(SRC), .ADDR_WIDTH(17), .DATA_WIDTH(12)
    ) u_dut (
      .clk(clk), .rst_n(rst_n[G]), .sram_addr(addr), .sram_dout(dout),
      .vga_r(cr), .vga_g(cg), .vga_b(cb), .vga_hsync(hs), .vga_vsync(vs),
      .vga_de(de), .frame_start(fs)
    );

    assign addr_w[G] = addr;
    assign rgb_w[G]  = {cr, cg, cb};
    assign de_w[G]   = de;
    assign fs_w[G]   = fs;

    // Registered-read SRAM; garbage on the bus while the reader is in reset
    always @(posedge clk) begin
      if (!rst_n[G]) dout <= 12'($urandom);
      else           dout <= pat(addr);
    end

    // Reference raster position, counting from reset release
    always @(posedge clk or negedge rst_n[G]) begin
      if (!rst_n[G]) begin
        mh <= 0;
        mv <= 0;
      end else if (mh == HT - 1) begin
        mh <= 0;
        mv <= (mv == VT - 1) ? 0 : mv + 1;
      end else begin
        mh <= mh + 1;
      end
    end

    // Stimulus side: push the expected response for the current raster position
    always @(negedge clk) begin
      if (!rst_n[G]) begin
        q.delete();
      end else begin
        drv_e.h    = 10'(mh);
        drv_e.v    = 10'(mv);
        drv_e.de   = (mh < HA) && (mv < VA);
        drv_e.addr = drv_e.de ? 17'((mv / 2) * SRC + mh / 2) : 17'd0;
        drv_e.hs   = !((mh >= HA + HFP) && (mh < HA + HFP + HS));
        drv_e.vs   = !((mv >= VA + VFP) && (mv < VA + VFP + VS));
        drv_e.fs   = (mh == 0) && (mv == 0);
        drv_e.rgb  = drv_e.de ? pat(drv_e.addr) : 12'd0;
        q.push_back(drv_e);
      end
    end

    // Monitor side: address is one stage behind the raster, pins three stages
    always @(negedge clk) begin
      #1;
      if (!rst_n[G]) begin
        checks++;
        if (addr !== 17'd0 || {cr, cg, cb} !== 12'd0 || de !== 1'b0 ||
            hs !== 1'b1 || vs !== 1'b1 || fs !== 1'b0) begin
          errors++;
          $display("FAIL rst%0d: got addr=%0d rgb=%h de=%b hs=%b vs=%b fs=%b, want 0 000 0 1 1 0",
                   G, addr, {cr, cg, cb}, de, hs, vs, fs);
        end
      end else begin
        if (q.size() >= 2) begin
          checks++;
          if (addr !== q[q.size()-2].addr) begin
            errors++;
            $display("FAIL addr%0d (%0d,%0d): got %0d want %0d", G,
                     q[q.size()-2].h, q[q.size()-2].v, addr, q[q.size()-2].addr);
          end
        end
        if (q.size() > 3) begin
          mon_e = q.pop_front();
          checks++;
          if ({cr, cg, cb} !== mon_e.rgb || de !== mon_e.de || hs !== mon_e.hs ||
              vs !== mon_e.vs || fs !== mon_e.fs) begin
            errors++;
            $display("FAIL pix%0d (%0d,%0d): got rgb=%h de=%b hs=%b vs=%b fs=%b want rgb=%h de=%b hs=%b vs=%b fs=%b",
                     G, mon_e.h, mon_e.v, {cr, cg, cb}, de, hs, vs, fs,
                     mon_e.rgb, mon_e.de, mon_e.hs, mon_e.vs, mon_e.fs);
          end
        end
      end
    end
  end

  task automatic dchk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, req);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    ov0    = 12'hF00;
    ov1    = 12'h0AB;
    rst_n  = 2'b11;
    #1 rst_n = 2'b00;
    repeat (5) @(posedge clk);
    #2 rst_n = 2'b11;

    // Alignment: red-only word 0 reaches the pins on edge 3
    for (int e = 1; e <= 10; e++) begin
      @(posedge clk); #1;
      if (e == 1) dchk("A_addr_e1", 32'(addr_w[0]), 32'd0);
      if (e == 2) dchk("A_de_e2", 32'(de_w[0]), 32'd0);
      if (e == 3) begin
        dchk("A_r_e3", 32'(rgb_w[0][11:8]), 32'hF);
        dchk("A_g_e3", 32'(rgb_w[0][7:4]), 32'h0);
        dchk("A_b_e3", 32'(rgb_w[0][3:0]), 32'h0);
        dchk("A_de_e3", 32'(de_w[0]), 32'd1);
        dchk("A_fs_e3", 32'(fs_w[0]), 32'd1);
      end
    end
    #1 rst_n = 2'b00;
    #1 dchk("A_async_rst_de", 32'(de_w), 32'd0);
    dchk("A_async_rst_rgb", 32'(rgb_w[0]), 32'd0);

    ov0 = 12'h123;
    ov1 = 12'h456;
    repeat (4) @(posedge clk);
    #2 rst_n = 2'b11;

    for (int e = 1; e <= 2600; e++) begin
      @(posedge clk); #1;
      case (e)
        3:    begin dchk("B_x0", 32'(rgb_w[0]), 32'h123); dchk("B_fs", 32'(fs_w[0]), 32'd1); end
        4:    dchk("B_x1", 32'(rgb_w[0]), 32'h123);
        5:    dchk("B_x2", 32'(rgb_w[0]), 32'h456);
        6:    dchk("B_x3", 32'(rgb_w[0]), 32'h456);
        7:    dchk("B_x4", 32'(rgb_w[0]), 32'h04F);
        184:  dchk("S_last_addr", 32'(addr_w[1]), 32'd31);
        186:  dchk("S_last_pix", 32'(rgb_w[1]), 32'h480);
        363:  begin dchk("S_wrap_addr", 32'(addr_w[1]), 32'd1); dchk("S_fs2", 32'(fs_w[1]), 32'd1); end
        364:  dchk("S_fs_once", 32'(fs_w[1]), 32'd0);
        640:  dchk("B_addr_639", 32'(addr_w[0]), 32'd319);
        641:  dchk("B_addr_blank", 32'(addr_w[0]), 32'd0);
        801:  dchk("B_line1_addr", 32'(addr_w[0]), 32'd0);
        803:  dchk("B_line1_pix", 32'(rgb_w[0]), 32'h123);
        1601: dchk("B_line2_addr", 32'(addr_w[0]), 32'd320);
        1603: dchk("B_line2_pix", 32'(rgb_w[0]), 32'hE45);
        1212: begin
          #1 rst_n[1] = 1'b0;
          #1 dchk("S_midrst_addr", 32'(addr_w[1]), 32'd0);
          dchk("S_midrst_de", 32'(de_w[1]), 32'd0);
        end
        1215: #1 rst_n[1] = 1'b1;
        1218: begin dchk("S_restart_fs", 32'(fs_w[1]), 32'd1); dchk("S_restart_pix", 32'(rgb_w[1]), 32'h123); end
        1900: begin
          #1 rst_n[0] = 1'b0;
          #1 dchk("B_midrst_addr", 32'(addr_w[0]), 32'd0);
          dchk("B_midrst_rgb", 32'(rgb_w[0]), 32'd0);
        end
        1903: #1 rst_n[0] = 1'b1;
        1906: begin dchk("B_restart_fs", 32'(fs_w[0]), 32'd1); dchk("B_restart_pix", 32'(rgb_w[0]), 32'h123); end
        default: ;
      endcase
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
